// File: rtl/rota_dogrula_pkg.sv
// ----------------------------------------------------------------------------
// rota_pkg
// Shared definitions for the route-code validator family.
//   ROTA_W          : width of a route code
//   ROTA_A..ROTA_D  : the four legal route codes
//   rota_listede()  : list-based membership helper for blocks that prefer an
//                     explicit table lookup over the bit-rule decoder
// ----------------------------------------------------------------------------
package rota_pkg;

    localparam int ROTA_W = 6;

    localparam logic [ROTA_W-1:0] ROTA_A = 6'h38;
    localparam logic [ROTA_W-1:0] ROTA_B = 6'h23;
    localparam logic [ROTA_W-1:0] ROTA_C = 6'h25;
    localparam logic [ROTA_W-1:0] ROTA_D = 6'h26;

    function automatic logic rota_listede(input logic [ROTA_W-1:0] r);
        return (r == ROTA_A) || (r == ROTA_B) || (r == ROTA_C) || (r == ROTA_D);
    endfunction

endpackage

// File: rtl/rota_dogrula_comb.sv
// ----------------------------------------------------------------------------
// rota_dogrula_comb
// Pure combinational route-code decoder, no registers.
// Ports:
//   rota       [5:0] in  : route code, bit 5 is MSB
//   rota_dogru       out : 1 iff rota is one of the four legal routes
// ----------------------------------------------------------------------------
module rota_dogrula_comb
    import rota_pkg::*;
(
    input  logic [ROTA_W-1:0] rota,
    output logic              rota_dogru
);

    logic [1:0] w_ust;
    logic [2:0] w_alt;
    logic       w_alt_sifir;
    logic       w_alt_iki;

    // Legal set expressed as a rule: MSB set, then either 11_000 or 00_xyz
    // with exactly two of x/y/z high.
    always_comb begin
        w_ust       = rota[4:3];
        w_alt       = rota[2:0];
        w_alt_sifir = (w_alt == 3'b000);
        w_alt_iki   = (w_alt == 3'b011) || (w_alt == 3'b101) || (w_alt == 3'b110);
        rota_dogru  = rota[5] &&
                      (((w_ust == 2'b11) && w_alt_sifir) ||
                       ((w_ust == 2'b00) && w_alt_iki));
    end

endmodule

// File: rtl/sat_sayac.sv
// ----------------------------------------------------------------------------
// sat_sayac
// Saturating up-counter with synchronous clear.
// Ports:
//   clk           in  : clock, rising edge
//   en            in  : count request for this cycle
//   clr           in  : synchronous clear, wins over en
//   count [W-1:0] out : current count, sticks at 2^W-1
// ----------------------------------------------------------------------------
module sat_sayac #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;
    logic         w_dolu;

    assign w_dolu = (r_count == {W{1'b1}});

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (en && !w_dolu) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/rota_dogrula.sv
// ----------------------------------------------------------------------------
// rota_dogrula
// Route-code validator with status logic.
// Ports:
//   clk                    in  : system clock, rising edge
//   rst                    in  : synchronous reset, active high
//   rota         [5:0]     in  : route code
//   rota_gecerli           in  : sample strobe
//   rota_dogru             out : combinational verdict of rota
//   rota_dogru_q           out : verdict of the last sampled code
//   dogru_sayac  [CNT_W-1:0] out : saturating count of legal samples
//   hata_sayac   [CNT_W-1:0] out : saturating count of illegal samples
//   hata                   out : sticky, an illegal code was sampled
// ----------------------------------------------------------------------------
module rota_dogrula
    import rota_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROTA_W-1:0] rota,
    input  logic              rota_gecerli,
    output logic              rota_dogru,
    output logic              rota_dogru_q,
    output logic [CNT_W-1:0]  dogru_sayac,
    output logic [CNT_W-1:0]  hata_sayac,
    output logic              hata
);

    logic w_dogru;
    logic w_dogru_en;
    logic w_hata_en;
    logic r_dogru_q;
    logic r_hata;

    rota_dogrula_comb u_comb (
        .rota       (rota),
        .rota_dogru (w_dogru)
    );

    // Verdict goes straight out; nothing registered sits on this path.
    assign rota_dogru = w_dogru;

    assign w_dogru_en = rota_gecerli && w_dogru;
    assign w_hata_en  = rota_gecerli && !w_dogru;

    sat_sayac #(.W(CNT_W)) u_dogru_sayac (
        .clk   (clk),
        .en    (w_dogru_en),
        .clr   (rst),
        .count (dogru_sayac)
    );

    sat_sayac #(.W(CNT_W)) u_hata_sayac (
        .clk   (clk),
        .en    (w_hata_en),
        .clr   (rst),
        .count (hata_sayac)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dogru_q <= 1'b0;
            r_hata    <= 1'b0;
        end else if (rota_gecerli) begin
            r_dogru_q <= w_dogru;
            if (!w_dogru) begin
                r_hata <= 1'b1;
            end
        end
    end

    assign rota_dogru_q = r_dogru_q;
    assign hata         = r_hata;

endmodule

// File: tb/tb_rota_dogrula.sv
module tb_rota_dogrula;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic [5:0] rota;
    logic       rota_gecerli;

    logic       dogru8, q8, h8;
    logic [7:0] d8, e8;
    logic       dogru2, q2, h2;
    logic [1:0] d2, e2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       q;
        logic       h;
        logic [7:0] d8;
        logic [7:0] e8;
        logic [1:0] d2;
        logic [1:0] e2;
    } exp_t;

    exp_t sb[$];
    exp_t m;

    rota_dogrula dut8 (
        .clk          (clk),
        .rst          (rst),
        .rota         (rota),
        .rota_gecerli (rota_gecerli),
        .rota_dogru   (dogru8),
        .rota_dogru_q (q8),
        .dogru_sayac  (d8),
        .hata_sayac   (e8),
        .hata         (h8)
    );

    rota_dogrula #(.CNT_W(2)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .rota         (rota),
        .rota_gecerli (rota_gecerli),
        .rota_dogru   (dogru2),
        .rota_dogru_q (q2),
        .dogru_sayac  (d2),
        .hata_sayac   (e2),
        .hata         (h2)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Hand-written legal list, independent of the bit-rule decoder.
    function automatic logic legal(input logic [5:0] c);
        return (c == 6'h38) || (c == 6'h23) || (c == 6'h25) || (c == 6'h26);
    endfunction

    task automatic chk_comb(input string name);
        chk({name, "_dogru8"}, {31'd0, dogru8}, {31'd0, legal(rota)});
        chk({name, "_dogru2"}, {31'd0, dogru2}, {31'd0, legal(rota)});
    endtask

    // Drive one cycle of stimulus and queue the state expected after its edge.
    task automatic cycle(input logic r, input logic g, input logic [5:0] c);
        @(negedge clk);
        rst          = r;
        rota_gecerli = g;
        rota         = c;
        #1;
        chk_comb("cyc_comb");
        if (r) begin
            m.q = 0; m.h = 0; m.d8 = 0; m.e8 = 0; m.d2 = 0; m.e2 = 0;
        end else if (g) begin
            m.q = legal(c);
            if (legal(c)) begin
                if (m.d8 != 8'hFF) m.d8 = m.d8 + 1;
                if (m.d2 != 2'h3)  m.d2 = m.d2 + 1;
            end else begin
                if (m.e8 != 8'hFF) m.e8 = m.e8 + 1;
                if (m.e2 != 2'h3)  m.e2 = m.e2 + 1;
                m.h = 1;
            end
        end
        sb.push_back(m);
    endtask

    // Monitor: one expectation per clocked stimulus cycle, checked after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_q8",  {31'd0, q8}, {31'd0, e.q});
            chk("sb_h8",  {31'd0, h8}, {31'd0, e.h});
            chk("sb_d8",  {24'd0, d8}, {24'd0, e.d8});
            chk("sb_e8",  {24'd0, e8}, {24'd0, e.e8});
            chk("sb_q2",  {31'd0, q2}, {31'd0, e.q});
            chk("sb_h2",  {31'd0, h2}, {31'd0, e.h});
            chk("sb_d2",  {30'd0, d2}, {30'd0, e.d2});
            chk("sb_e2",  {30'd0, e2}, {30'd0, e.e2});
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] near [5];
        logic [1:0] sat_exp [5];
        near    = '{6'h18, 6'h39, 6'h27, 6'h21, 6'h07};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        m = '{q: 0, h: 0, d8: 0, e8: 0, d2: 0, e2: 0};

        clk_en       = 1'b0;
        rst          = 1'b0;
        rota_gecerli = 1'b0;
        rota         = 6'h00;

        // Exhaustive sweep with the clock stopped.
        for (int i = 0; i < 64; i++) begin
            rota = 6'(i);
            #1;
            chk_comb("sweep");
        end
        for (int i = 0; i < 5; i++) begin
            rota = near[i];
            #1;
            chk("near_miss", {31'd0, dogru8}, 32'd0);
        end
        rota = 6'h38; rst = 1'b1; #1;
        chk("comb_in_reset", {31'd0, dogru8}, 32'd1);
        rst = 1'b0;

        clk_en = 1'b1;

        // Reset then three samples.
        cycle(1, 0, 6'h00);
        cycle(0, 1, 6'h38);
        cycle(0, 1, 6'h10);
        cycle(0, 1, 6'h26);
        @(posedge clk); #2;
        chk("seq_dogru", {24'd0, d8}, 32'd2);
        chk("seq_hata_sayac", {24'd0, e8}, 32'd1);
        chk("seq_hata", {31'd0, h8}, 32'd1);
        chk("seq_q", {31'd0, q8}, 32'd1);

        // Saturation on the 2-bit instance.
        cycle(1, 0, 6'h00);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 6'h25);
            @(posedge clk); #2;
            chk("sat_dogru2", {30'd0, d2}, {30'd0, sat_exp[i]});
            chk("sat_hata2", {30'd0, e2}, 32'd0);
        end
        chk("sat_dogru8", {24'd0, d8}, 32'd5);
        // Other counter still moves while the legal one is pinned.
        cycle(0, 1, 6'h00);
        @(posedge clk); #2;
        chk("sat_other_e2", {30'd0, e2}, 32'd1);
        chk("sat_other_d2", {30'd0, d2}, 32'd3);
        chk("sat_other_q2", {31'd0, q2}, 32'd0);

        // Idle hold: codes move, strobe low.
        for (int i = 0; i < 64; i++) begin
            cycle(0, 0, 6'(i));
        end
        @(posedge clk); #2;
        chk("idle_d8", {24'd0, d8}, 32'd5);
        chk("idle_e8", {24'd0, e8}, 32'd1);
        chk("idle_h8", {31'd0, h8}, 32'd1);

        // Back-to-back legal then reset with a strobe on the same edge.
        cycle(0, 1, 6'h23);
        cycle(1, 1, 6'h00);
        @(posedge clk); #2;
        chk("rstpri_d8", {24'd0, d8}, 32'd0);
        chk("rstpri_e8", {24'd0, e8}, 32'd0);
        chk("rstpri_h8", {31'd0, h8}, 32'd0);
        chk("rstpri_q8", {31'd0, q8}, 32'd0);
        cycle(0, 1, 6'h26);
        cycle(0, 0, 6'h00);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rota_dogrula.md
Name: rota_dogrula

Overview:
- Route-code validator. Checks a 6-bit route code `rota` against the fixed set of legal routes.
- Produces a purely combinational verdict `rota_dogru`.
- Also provides a registered copy of the verdict and saturating legal/illegal sample counters for status reporting.
- Sits between the route-entry logic and the controller that acts on accepted routes.

Parameters:
- CNT_W, 8, width of the legal and illegal sample counters (minimum 2).

Ports:
- clk  input  1  system clock; all registers update on rising edge.
- rst  input  1  synchronous reset, active-high.
- rota  input  6  route code; bit 5 is MSB.
- rota_gecerli  input  1  sample strobe; when high, `rota` is latched into the status logic this cycle.
- rota_dogru  output  1  combinational: 1 iff `rota` is a legal route.
- rota_dogru_q  output  1  registered verdict of the last sampled `rota`.
- dogru_sayac  output  CNT_W  saturating count of sampled legal routes.
- hata_sayac  output  CNT_W  saturating count of sampled illegal routes.
- hata  output  1  sticky flag: at least one illegal route sampled since reset.

Behaviour:
- Legal set, exactly four codes: 6'b111000 (0x38), 6'b100011 (0x23), 6'b100101 (0x25), 6'b100110 (0x26).
- Equivalent rule: bit5=1 AND either
  - bits[4:3]=11 with bits[2:0]=000, or
  - bits[4:3]=00 with exactly two of bits[2:0] set.
- All other 60 codes are illegal.
- `rota_dogru`:
  - Zero-latency function of `rota` only, with no path through any register.
  - Valid as soon as `rota` settles, even with clk idle and regardless of rst.
  - No X on the output for any defined input.
- Reset: when rst=1 at a rising edge, set rota_dogru_q=0, dogru_sayac=0, hata_sayac=0 and hata=0.
  - Reset has priority over rota_gecerli in the same cycle.
- Sample cycle (rst=0, rota_gecerli=1):
  - rota_dogru_q <= rota_dogru.
  - If legal: dogru_sayac increments by 1.
  - If illegal: hata_sayac increments by 1 and hata <= 1.
  - One-cycle latency: registered outputs reflect the sample on the edge where rota_gecerli was high.
- Idle cycle (rota_gecerli=0): all registers hold their values.
- Saturation:
  - Each counter stops at 2^CNT_W-1 and does not wrap.
  - Further samples of that class leave it unchanged.
  - The other counter and `hata` still update normally.
- `hata` clears only on reset.
- Reset mid-stream discards any sample presented in the reset cycle; counting restarts from 0 on the next sample.
- Back-to-back strobes: every cycle with rota_gecerli=1 is a separate sample, with no minimum gap.

Decomposition:
- Shared package rota_pkg:
  - constants ROTA_W=6;
  - ROTA_A=6'h38, ROTA_B=6'h23, ROTA_C=6'h25, ROTA_D=6'h26.
- Sub-module rota_dogrula_comb: pure combinational decoder, rota[5:0] -> rota_dogru.
  - Instantiated once in the top.
  - Reusable by other blocks needing the verdict without status logic.
- One saturating-counter sub-module, sat_sayac (en, clr, count), instantiated twice.

Test Plan:
- Exhaustive combinational sweep, clk held low: rota = 0..63, check after 1 ns. rota_dogru=1 only for 0x23, 0x25, 0x26, 0x38; 0 for the other 60 codes.
- Near-miss codes: 0x18, 0x39, 0x27, 0x21, 0x07 -> rota_dogru=0 for each.
- Reset then samples, rota_gecerli=1 for one cycle each with 0x38, 0x10, 0x26 -> after the third edge: dogru_sayac=2, hata_sayac=1, hata=1, rota_dogru_q=1.
- Idle hold: rota toggles through 0x00..0x3F with rota_gecerli=0 -> counters, hata and rota_dogru_q unchanged; rota_dogru still tracks rota.
- Saturation, CNT_W=2: five consecutive samples of 0x25 -> dogru_sayac reads 1, 2, 3, 3, 3; hata_sayac stays 0.
- Reset priority: rst=1 and rota_gecerli=1 with rota=0x00 on the same edge -> all counters 0, hata=0, rota_dogru_q=0.
